// File: rtl/vipmod_morph_sequencer.sv
// Frame-synchronous op sequencer for a two-stage 3x3 binary morphology chain.
// Latches per-frame mode requests, commits them on vsync rise, checks geometry and paces frame_done.
module vipmod_morph_sequencer #(
    parameter int IMG_HDISP = 640,
    parameter int IMG_VDISP = 480,
    parameter int DRAIN_CYC = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_valid,
    output logic        cfg_ready,
    input  logic [2:0]  cfg_mode,
    input  logic        per_frame_vsync,
    input  logic        per_frame_href,
    input  logic        per_frame_clken,
    output logic [1:0]  stage1_op,
    output logic [1:0]  stage2_op,
    output logic [2:0]  active_mode,
    output logic        busy,
    output logic        frame_done,
    output logic        geom_err,
    output logic        cfg_err,
    output logic [15:0] frame_cnt
);

    localparam logic [9:0] HDISP      = 10'(IMG_HDISP);
    localparam logic [9:0] VDISP      = 10'(IMG_VDISP);
    localparam logic [9:0] CNT_MAX    = 10'h3FF;
    localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYC - 1);

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_DRAIN} state_t;

    state_t      r_state;
    logic        r_vsync_d;
    logic        r_href_d;
    logic        r_pend_full;
    logic [2:0]  r_pend_mode;
    logic [1:0]  r_stage1_op;
    logic [1:0]  r_stage2_op;
    logic [2:0]  r_active_mode;
    logic        r_frame_done;
    logic        r_geom_err;
    logic        r_cfg_err;
    logic [15:0] r_frame_cnt;
    logic [7:0]  r_drain_cnt;
    logic [9:0]  r_pix_cnt;
    logic [9:0]  r_line_cnt;
    logic        r_line_err;

    // Packed {stage1_op, stage2_op} for each legal mode.
    function automatic logic [3:0] map_mode(input logic [2:0] mode);
        case (mode)
            3'd1:    map_mode = 4'b01_00;
            3'd2:    map_mode = 4'b10_00;
            3'd3:    map_mode = 4'b01_10;
            3'd4:    map_mode = 4'b10_01;
            default: map_mode = 4'b00_00;
        endcase
    endfunction

    logic       w_vs_rise;
    logic       w_vs_fall;
    logic       w_href_rise;
    logic       w_href_fall;
    logic       w_cfg_acc;
    logic       w_cfg_rsvd;
    logic       w_geom_en;
    logic       w_drain_tc;
    logic       w_start;
    logic [3:0] w_map;

    assign w_vs_rise   = per_frame_vsync & ~r_vsync_d;
    assign w_vs_fall   = ~per_frame_vsync & r_vsync_d;
    assign w_href_rise = per_frame_href & ~r_href_d;
    assign w_href_fall = ~per_frame_href & r_href_d;
    assign w_cfg_acc   = cfg_valid & ~r_pend_full;
    assign w_cfg_rsvd  = (cfg_mode > 3'd4);
    assign w_geom_en   = (r_state == S_ACTIVE) & per_frame_vsync;
    assign w_drain_tc  = (r_state == S_DRAIN) & (r_drain_cnt == DRAIN_LAST);
    assign w_start     = w_vs_rise & (r_state != S_ACTIVE);
    assign w_map       = map_mode(r_pend_mode);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_vsync_d     <= 1'b1;  // a frame already running at reset release must not look like a rise
            r_href_d      <= 1'b0;
            r_pend_full   <= 1'b0;
            r_pend_mode   <= 3'd0;
            r_stage1_op   <= 2'b00;
            r_stage2_op   <= 2'b00;
            r_active_mode <= 3'd0;
            r_frame_done  <= 1'b0;
            r_geom_err    <= 1'b0;
            r_cfg_err     <= 1'b0;
            r_frame_cnt   <= 16'd0;
            r_drain_cnt   <= 8'd0;
            r_pix_cnt     <= 10'd0;
            r_line_cnt    <= 10'd0;
            r_line_err    <= 1'b0;
        end else begin
            r_vsync_d    <= per_frame_vsync;
            r_href_d     <= per_frame_href;
            r_frame_done <= 1'b0;
            r_cfg_err    <= w_cfg_acc & w_cfg_rsvd;

            if (w_cfg_acc && !w_cfg_rsvd) begin
                r_pend_full <= 1'b1;
                r_pend_mode <= cfg_mode;
            end

            if (w_geom_en) begin
                if (w_href_rise)
                    r_pix_cnt <= {9'd0, per_frame_clken};
                else if (per_frame_href && per_frame_clken && r_pix_cnt != CNT_MAX)
                    r_pix_cnt <= r_pix_cnt + 10'd1;
                if (w_href_fall) begin
                    if (r_pix_cnt != HDISP)
                        r_line_err <= 1'b1;
                    if (r_line_cnt != CNT_MAX)
                        r_line_cnt <= r_line_cnt + 10'd1;
                end
            end

            case (r_state)
                S_IDLE: ;
                S_ACTIVE: begin
                    if (w_vs_fall) begin
                        r_geom_err  <= r_line_err | (r_line_cnt != VDISP);
                        r_drain_cnt <= 8'd0;
                        r_state     <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // An early vsync rise closes the draining frame in the same cycle.
                    if (w_vs_rise || w_drain_tc) begin
                        r_frame_done <= 1'b1;
                        r_frame_cnt  <= r_frame_cnt + 16'd1;
                    end
                    if (w_drain_tc)
                        r_state <= S_IDLE;
                    else
                        r_drain_cnt <= r_drain_cnt + 8'd1;
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_start) begin
                r_state    <= S_ACTIVE;
                r_pix_cnt  <= 10'd0;
                r_line_cnt <= 10'd0;
                r_line_err <= 1'b0;
                if (r_pend_full) begin
                    r_stage1_op   <= w_map[3:2];
                    r_stage2_op   <= w_map[1:0];
                    r_active_mode <= r_pend_mode;
                    r_pend_full   <= 1'b0;
                end
            end
        end
    end

    assign cfg_ready   = ~r_pend_full;
    assign stage1_op   = r_stage1_op;
    assign stage2_op   = r_stage2_op;
    assign active_mode = r_active_mode;
    assign busy        = (r_state != S_IDLE);
    assign frame_done  = r_frame_done;
    assign geom_err    = r_geom_err;
    assign cfg_err     = r_cfg_err;
    assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vipmod_morph_sequencer.sv
// Randomised bench for vipmod_morph_sequencer against a frame-level reference model.
module tb_vipmod_morph_sequencer;

    localparam int HD = 20;
    localparam int VD = 6;
    localparam int DC = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [2:0]  cfg_mode;
    logic        per_frame_vsync;
    logic        per_frame_href;
    logic        per_frame_clken;
    logic [1:0]  stage1_op;
    logic [1:0]  stage2_op;
    logic [2:0]  active_mode;
    logic        busy;
    logic        frame_done;
    logic        geom_err;
    logic        cfg_err;
    logic [15:0] frame_cnt;

    always #5 clk = ~clk;

    vipmod_morph_sequencer #(
        .IMG_HDISP (HD),
        .IMG_VDISP (VD),
        .DRAIN_CYC (DC)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_mode        (cfg_mode),
        .per_frame_vsync (per_frame_vsync),
        .per_frame_href  (per_frame_href),
        .per_frame_clken (per_frame_clken),
        .stage1_op       (stage1_op),
        .stage2_op       (stage2_op),
        .active_mode     (active_mode),
        .busy            (busy),
        .frame_done      (frame_done),
        .geom_err        (geom_err),
        .cfg_err         (cfg_err),
        .frame_cnt       (frame_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: pending slot, committed mode, frame counter, geometry verdict.
    int          s1_tab [5] = '{0, 1, 2, 1, 2};
    int          s2_tab [5] = '{0, 0, 0, 2, 1};
    bit          m_pend;
    int          m_pmode;
    int          m_mode;
    logic [15:0] m_fcnt;
    bit          m_geom;
    int          lines_sent;
    bit          line_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_pend = 0; m_pmode = 0; m_mode = 0; m_fcnt = 16'd0; m_geom = 0;
    endtask

    task automatic check_ops(input string tag);
        check({tag, "_s1"},   32'(stage1_op),   32'(s1_tab[m_mode]));
        check({tag, "_s2"},   32'(stage2_op),   32'(s2_tab[m_mode]));
        check({tag, "_mode"}, 32'(active_mode), 32'(m_mode));
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        model_reset();
        check_ops("rst");
        check("rst_ready", 32'(cfg_ready),  32'd1);
        check("rst_busy",  32'(busy),       32'd0);
        check("rst_done",  32'(frame_done), 32'd0);
        check("rst_geom",  32'(geom_err),   32'd0);
        check("rst_cerr",  32'(cfg_err),    32'd0);
        check("rst_fcnt",  32'(frame_cnt),  32'd0);
    endtask

    task automatic cfg_send(input int mode);
        bit acc;
        check("cfg_ready_pre", 32'(cfg_ready), 32'(!m_pend));
        acc = !m_pend;
        cfg_valid = 1'b1;
        cfg_mode  = 3'(mode);
        tick();
        cfg_valid = 1'b0;
        if (acc && mode <= 4) begin
            m_pend  = 1;
            m_pmode = mode;
        end
        check("cfg_err", 32'(cfg_err), 32'(acc && mode > 4));
        check("cfg_ready_post", 32'(cfg_ready), 32'(!m_pend));
        tick();
        check("cfg_err_clr", 32'(cfg_err), 32'd0);
    endtask

    task automatic send_line(input int len);
        int n = 0;
        per_frame_href = 1'b1;
        while (n < len) begin
            per_frame_clken = ($urandom_range(0, 3) != 0);
            if (per_frame_clken) n++;
            tick();
        end
        per_frame_href  = 1'b0;
        per_frame_clken = 1'b0;
        tick();
        tick();
        lines_sent++;
        if (len != HD) line_bad = 1;
    endtask

    task automatic commit_model();
        if (m_pend) begin
            m_mode = m_pmode;
            m_pend = 0;
        end
        lines_sent = 0;
        line_bad   = 0;
    endtask

    task automatic frame_start();
        per_frame_vsync = 1'b1;
        tick();
        commit_model();
        check_ops("start");
        check("start_ready", 32'(cfg_ready), 32'(!m_pend));
        check("start_busy",  32'(busy),      32'd1);
        tick();
    endtask

    task automatic frame_end(input bit exp_done);
        int done_n = 0;
        int done_pos = 0;
        tick();
        per_frame_vsync = 1'b0;
        for (int k = 1; k <= DC + 3; k++) begin
            tick();
            if (frame_done === 1'b1) begin
                done_n++;
                done_pos = k;
            end
        end
        if (exp_done) begin
            m_geom = line_bad || (lines_sent != VD);
            m_fcnt = m_fcnt + 16'd1;
            check("done_cnt", 32'(done_n), 32'd1);
            check("done_pos", 32'(done_pos), 32'(DC + 1));
        end else begin
            check("no_done", 32'(done_n), 32'd0);
        end
        check("end_geom", 32'(geom_err),  32'(m_geom));
        check("end_fcnt", 32'(frame_cnt), 32'(m_fcnt));
        check("end_busy", 32'(busy),      32'd0);
        check_ops("end");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; cfg_valid = 1'b0; cfg_mode = 3'd0;
        per_frame_vsync = 1'b0; per_frame_href = 1'b0; per_frame_clken = 1'b0;
        lines_sent = 0; line_bad = 0;
        model_reset();
        @(negedge clk);
        do_reset();

        // Pending request before the first frame, committed at its rise.
        cfg_send(3);
        frame_start();
        for (int i = 0; i < VD; i++) send_line(HD);
        frame_end(1);

        // Short line, then a clean frame.
        frame_start();
        for (int i = 0; i < VD; i++) send_line((i == 2) ? HD - 1 : HD);
        frame_end(1);
        frame_start();
        for (int i = 0; i < VD; i++) send_line(HD);
        frame_end(1);

        // Mid-frame requests must not disturb the running frame.
        cfg_send(1);
        frame_start();
        send_line(HD);
        cfg_send(6);
        check_ops("rsvd");
        cfg_send(4);
        check_ops("mid");
        for (int i = 1; i < VD; i++) send_line(HD);
        frame_end(1);
        frame_start();
        cfg_send(2);
        for (int i = 0; i < VD; i++) send_line(HD);

        // Vsync rises again while the previous frame is still draining.
        tick();
        per_frame_vsync = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("drain_early_done", 32'(frame_done), 32'd0);
        end
        per_frame_vsync = 1'b1;
        tick();
        m_geom = line_bad || (lines_sent != VD);
        m_fcnt = m_fcnt + 16'd1;
        commit_model();
        check("drain_rise_done", 32'(frame_done), 32'd1);
        check("drain_rise_fcnt", 32'(frame_cnt),  32'(m_fcnt));
        check("drain_rise_geom", 32'(geom_err),   32'(m_geom));
        check("drain_rise_busy", 32'(busy),       32'd1);
        check_ops("drain_rise");
        tick();
        check("drain_rise_pulse", 32'(frame_done), 32'd0);
        for (int i = 0; i < VD; i++) send_line(HD);
        frame_end(1);

        // Reset in the middle of a frame: the remainder of that frame is ignored.
        frame_start();
        send_line(HD);
        send_line(HD);
        cfg_send(1);
        do_reset();
        for (int i = 0; i < VD - 2; i++) send_line(HD);
        frame_end(0);
        cfg_send(2);
        frame_start();
        for (int i = 0; i < VD; i++) send_line(HD);
        frame_end(1);

        // Random modes and random geometry defects.
        for (int r = 0; r < 8; r++) begin
            int defect;
            int bad_idx;
            int nlines;
            if ($urandom_range(0, 1) == 1) cfg_send(int'($urandom_range(0, 7)));
            frame_start();
            defect  = int'($urandom_range(0, 4));
            bad_idx = int'($urandom_range(0, VD - 1));
            nlines  = (defect == 3) ? VD - 1 : (defect == 4) ? VD + 1 : VD;
            for (int i = 0; i < nlines; i++) begin
                int len = HD;
                if (defect == 1 && i == bad_idx) len = HD - 1;
                if (defect == 2 && i == bad_idx) len = HD + int'($urandom_range(1, 3));
                send_line(len);
                if (i == 1 && $urandom_range(0, 1) == 1) begin
                    cfg_send(int'($urandom_range(0, 7)));
                    check_ops("rand_mid");
                end
            end
            frame_end(1);
        end

        // Frame counter wrap.
        force dut.r_frame_cnt = 16'hFFFF;
        #1;
        release dut.r_frame_cnt;
        m_fcnt = 16'hFFFF;
        check("wrap_pre", 32'(frame_cnt), 32'h0000FFFF);
        @(negedge clk);
        frame_start();
        for (int i = 0; i < VD; i++) send_line(HD);
        frame_end(1);
        check("wrap_zero", 32'(frame_cnt), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
